contador_salidas: RTL and testbench
===================================

// Module: contador_salidas
// PURPOSE
//  Statistics stage directly downstream of the D0/D1 output FIFOs of the interconnect.
//  - Snoops every pop issued to D0/D1.
//  - Counts delivered words per output, and in total.
//  - Checks the destination bit of each popped word and counts misrouted words.
//  - Reports any counter on a req/idx handshake, only while the device is idle.
// PARAMETERS
//  CNT_W   5   width of every counter and of data_cnt; counters saturate at 2**CNT_W-1
//  DATA_W  6   width of data_out0/data_out1 words
//  DEST_B  4   bit index of the destination field inside a word (0 = D0, 1 = D1)
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset      in   1       synchronous, active-high; clears everything
//  init       in   1       synchronous clear of counters and outputs; same effect as reset
//  idle       in   1       device idle indication from the main FSM
//  pop_D0     in   1       pop issued to FIFO D0
//  pop_D1     in   1       pop issued to FIFO D1
//  empty_D0   in   1       D0 FIFO empty flag
//  empty_D1   in   1       D1 FIFO empty flag
//  data_out0  in   DATA_W  D0 read data, valid the cycle after an accepted pop
//  data_out1  in   DATA_W  D1 read data, valid the cycle after an accepted pop
//  req        in   1       counter read request
//  idx        in   2       selects the counter: 0=D0 words, 1=D1 words, 2=total, 3=misrouted
//  data_cnt   out  CNT_W   selected counter value
//  valid_cnt  out  1       data_cnt is valid
// BEHAVIOUR
//  Reset / init
//   - When reset=1 or init=1 at a posedge: cnt_d0, cnt_d1, cnt_tot and cnt_err go to 0.
//   - Pipeline flags chk0/chk1 go to 0; data_cnt=0; valid_cnt=0.
//   - reset or init asserted mid-operation discards any in-flight check.
//  Accepted pop
//   - accD0 = pop_D0 & ~empty_D0; accD1 = pop_D1 & ~empty_D1.
//   - A pop while empty is ignored: no count and no check.
//  Word counters (1-cycle latency)
//   - An edge sampling accD0=1 increments cnt_d0; the same applies to accD1 and cnt_d1.
//   - cnt_tot adds accD0+accD1, so it adds 2 when both pops are accepted in one cycle.
//  Route check (2-cycle latency)
//   - chk0 <= accD0 and chk1 <= accD1.
//   - On the next edge, if chk0 & data_out0[DEST_B]!=0, cnt_err increments.
//   - If chk1 & data_out1[DEST_B]!=1, cnt_err increments.
//   - Both mismatches in the same cycle add 2.
//  Saturation
//   - Every counter stops at 2**CNT_W-1 and never wraps.
//   - Any add that would exceed the maximum clamps to the maximum.
//  Request FSM (states RPT_IDLE and RPT_VALID)
//   - RPT_IDLE: when req & idle is sampled, the FSM goes to RPT_VALID.
//     data_cnt <= counter[idx], using the pre-edge value; valid_cnt <= 1.
//   - RPT_VALID, while req & idle holds: stay, and refresh data_cnt from counter[idx] every cycle.
//     A change of idx is honoured the next cycle.
//   - RPT_VALID, when req=0 or idle=0: go to RPT_IDLE with valid_cnt <= 0 and data_cnt <= 0.
//   - req while idle=0 is ignored; the outputs stay at 0.
//  Counting continues in every FSM state; a read never clears a counter.
// TESTING
//  - Reset: assert reset for 2 cycles while pops are active.
//    -> all counters 0, valid_cnt=0, data_cnt=0.
//  - Five pops on D0 with dest bit 0, then idle=1, req=1, idx=0.
//    -> valid_cnt=1 and data_cnt=5 one cycle after req; idx=3 -> 0.
//  - Simultaneous pops on D0 and D1, 3 cycles.
//    -> idx=2 reads 6; idx=1 reads 3.
//  - One D1 word with dest bit 0, plus pop_D0 while empty_D0=1.
//    -> idx=3 reads 1; idx=0 reads 0.
//  - 40 accepted pops on D0 with CNT_W=5.
//    -> idx=0 and idx=2 read 31 (saturated, no wrap).
//  - req=1 with idle=0 -> valid_cnt stays 0; idle rises -> valid_cnt=1 next cycle.
//    Assert init -> counters and valid_cnt = 0 on the next cycle.

Source files
------------

// File: rtl/contador_salidas.sv
// Output statistics stage: snoops D0/D1 pops, keeps saturating word/misroute
// counters and reports a selected counter on a req/idx handshake while idle.
module contador_salidas #(
  parameter int CNT_W  = 5,
  parameter int DATA_W = 6,
  parameter int DEST_B = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              idle,
  input  logic              pop_D0,
  input  logic              pop_D1,
  input  logic              empty_D0,
  input  logic              empty_D1,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  input  logic              req,
  input  logic [1:0]        idx,
  output logic [CNT_W-1:0]  data_cnt,
  output logic              valid_cnt
);

  // state     | meaning
  // RPT_IDLE  | no report in progress, outputs held at zero
  // RPT_VALID | req & idle seen, data_cnt refreshed from counter[idx] each cycle
  typedef enum logic {
    RPT_IDLE  = 1'b0,
    RPT_VALID = 1'b1
  } rpt_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum > {1'b0, CNT_MAX}) return CNT_MAX;
    return sum[CNT_W-1:0];
  endfunction

  logic clr;
  logic acc_d0, acc_d1;
  logic err_d0, err_d1;

  logic [CNT_W-1:0] cnt_d0_q, cnt_d0_d;
  logic [CNT_W-1:0] cnt_d1_q, cnt_d1_d;
  logic [CNT_W-1:0] cnt_tot_q, cnt_tot_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;
  logic             chk0_q, chk1_q;

  rpt_state_e       state_q, state_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic             valid_cnt_q, valid_cnt_d;
  logic [CNT_W-1:0] cnt_sel;

  // Only the destination bit of each word is inspected.
  logic unused_data;
  assign unused_data = ^{data_out0, data_out1};

  assign clr    = reset | init;
  assign acc_d0 = pop_D0 & ~empty_D0;
  assign acc_d1 = pop_D1 & ~empty_D1;

  // Read data lands one cycle after the accepted pop, hence the chk flags.
  assign err_d0 = chk0_q & data_out0[DEST_B];
  assign err_d1 = chk1_q & ~data_out1[DEST_B];

  always_comb begin
    cnt_d0_d  = sat_add(cnt_d0_q, {1'b0, acc_d0});
    cnt_d1_d  = sat_add(cnt_d1_q, {1'b0, acc_d1});
    cnt_tot_d = sat_add(cnt_tot_q, {1'b0, acc_d0} + {1'b0, acc_d1});
    cnt_err_d = sat_add(cnt_err_q, {1'b0, err_d0} + {1'b0, err_d1});
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_d0_q  <= '0;
      cnt_d1_q  <= '0;
      cnt_tot_q <= '0;
      cnt_err_q <= '0;
      chk0_q    <= 1'b0;
      chk1_q    <= 1'b0;
    end else begin
      cnt_d0_q  <= cnt_d0_d;
      cnt_d1_q  <= cnt_d1_d;
      cnt_tot_q <= cnt_tot_d;
      cnt_err_q <= cnt_err_d;
      chk0_q    <= acc_d0;
      chk1_q    <= acc_d1;
    end
  end

  always_comb begin
    cnt_sel = '0;
    case (idx)
      2'd0:    cnt_sel = cnt_d0_q;
      2'd1:    cnt_sel = cnt_d1_q;
      2'd2:    cnt_sel = cnt_tot_q;
      default: cnt_sel = cnt_err_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    data_cnt_d  = '0;
    valid_cnt_d = 1'b0;
    case (state_q)
      RPT_IDLE: begin
        if (req && idle) begin
          state_d     = RPT_VALID;
          data_cnt_d  = cnt_sel;
          valid_cnt_d = 1'b1;
        end
      end
      RPT_VALID: begin
        if (req && idle) begin
          data_cnt_d  = cnt_sel;
          valid_cnt_d = 1'b1;
        end else begin
          state_d = RPT_IDLE;
        end
      end
      default: state_d = RPT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= RPT_IDLE;
      data_cnt_q  <= '0;
      valid_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_cnt_q  <= data_cnt_d;
      valid_cnt_q <= valid_cnt_d;
    end
  end

  assign data_cnt  = data_cnt_q;
  assign valid_cnt = valid_cnt_q;

endmodule

// File: tb/tb_contador_salidas.sv
// Bench for contador_salidas: directed scenarios, a count-level reference model
// compared every cycle, plus literal readback checks.
module tb_contador_salidas;

  localparam int CNT_W  = 5;
  localparam int DATA_W = 6;
  localparam int DEST_B = 4;
  localparam int MAXV   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset, init, idle;
  logic              pop_D0, pop_D1, empty_D0, empty_D1;
  logic [DATA_W-1:0] data_out0, data_out1;
  logic              req;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  data_cnt;
  logic              valid_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  contador_salidas #(.CNT_W(CNT_W), .DATA_W(DATA_W), .DEST_B(DEST_B)) dut (
    .clk(clk), .reset(reset), .init(init), .idle(idle),
    .pop_D0(pop_D0), .pop_D1(pop_D1), .empty_D0(empty_D0), .empty_D1(empty_D1),
    .data_out0(data_out0), .data_out1(data_out1),
    .req(req), .idx(idx), .data_cnt(data_cnt), .valid_cnt(valid_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: counts words and misroutes as plain integers.
  int m_cnt [4];
  int m_pend0, m_pend1, m_valid, m_data;
  int a0, a1, e;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    m_pend0 = 0; m_pend1 = 0; m_valid = 0; m_data = 0;
  end

  always @(posedge clk) begin
    if (reset || init) begin
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      m_pend0 = 0; m_pend1 = 0; m_valid = 0; m_data = 0;
    end else begin
      if (req && idle) begin
        m_data  = m_cnt[idx];
        m_valid = 1;
      end else begin
        m_data  = 0;
        m_valid = 0;
      end
      a0 = (pop_D0 && !empty_D0) ? 1 : 0;
      a1 = (pop_D1 && !empty_D1) ? 1 : 0;
      e  = ((m_pend0 != 0) && data_out0[DEST_B] != 1'b0) ? 1 : 0;
      e += ((m_pend1 != 0) && data_out1[DEST_B] != 1'b1) ? 1 : 0;
      m_cnt[0] = sat(m_cnt[0] + a0);
      m_cnt[1] = sat(m_cnt[1] + a1);
      m_cnt[2] = sat(m_cnt[2] + a0 + a1);
      m_cnt[3] = sat(m_cnt[3] + e);
      m_pend0 = a0;
      m_pend1 = a1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_vec++;
      if (data_cnt !== m_data[CNT_W-1:0] || valid_cnt !== (m_valid != 0)) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t data_cnt=%0d valid_cnt=%0b required data_cnt=%0d valid_cnt=%0d",
                 $time, data_cnt, valid_cnt, m_data, m_valid);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] i, input int exp, input string nm);
    @(negedge clk);
    req = 1'b1; idle = 1'b1; idx = i;
    @(negedge clk);
    check(nm, int'(data_cnt), exp);
    check({nm, "_valid"}, int'(valid_cnt), 1);
  endtask

  task automatic rd_release();
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("release_valid", int'(valid_cnt), 0);
    check("release_data", int'(data_cnt), 0);
  endtask

  task automatic pops(input int n, input bit p0, input bit e0, input bit p1, input bit e1);
    repeat (n) begin
      @(negedge clk);
      pop_D0 = p0; empty_D0 = e0; pop_D1 = p1; empty_D1 = e1;
    end
    @(negedge clk);
    pop_D0 = 1'b0; pop_D1 = 1'b0; empty_D0 = 1'b0; empty_D1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_init();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; idle = 1'b0; req = 1'b0; idx = 2'd0;
    pop_D0 = 1'b1; pop_D1 = 1'b1; empty_D0 = 1'b0; empty_D1 = 1'b0;
    data_out0 = 6'h03; data_out1 = 6'h05;
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; pop_D0 = 1'b0; pop_D1 = 1'b0; data_out1 = 6'h10;
    check("reset_valid", int'(valid_cnt), 0);
    check("reset_data", int'(data_cnt), 0);
    rd(2'd0, 0, "reset_d0");
    rd(2'd1, 0, "reset_d1");
    rd(2'd2, 0, "reset_tot");
    rd(2'd3, 0, "reset_err");
    rd_release();

    // five well-routed D0 words
    pops(5, 1, 0, 0, 0);
    rd(2'd0, 5, "five_d0");
    rd(2'd3, 0, "five_err");
    rd_release();

    // three cycles of simultaneous pops
    pulse_init();
    pops(3, 1, 0, 1, 0);
    rd(2'd2, 6, "dual_tot");
    rd(2'd1, 3, "dual_d1");
    rd(2'd0, 3, "dual_d0");
    rd_release();

    // in-flight misroute check discarded by init
    pulse_init();
    data_out1 = 6'h05;
    @(negedge clk);
    pop_D1 = 1'b1;
    @(negedge clk);
    pop_D1 = 1'b0; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (2) @(negedge clk);
    rd(2'd3, 0, "inflight_err");
    rd_release();

    // misrouted D1 word plus pop on empty D0
    pops(1, 1, 1, 1, 0);
    data_out1 = 6'h10;
    rd(2'd3, 1, "misroute_err");
    rd(2'd0, 0, "empty_d0");
    rd(2'd1, 1, "misroute_d1");
    rd_release();

    // saturation
    pulse_init();
    pops(40, 1, 0, 0, 0);
    rd(2'd0, 31, "sat_d0");
    rd(2'd2, 31, "sat_tot");
    rd_release();
    pulse_init();
    pops(15, 1, 0, 1, 0);
    rd(2'd2, 30, "near_sat_tot");
    rd_release();
    pops(1, 1, 0, 1, 0);
    rd(2'd2, 31, "clamp2_tot");
    rd(2'd0, 16, "clamp2_d0");
    rd_release();

    // req gated by idle, then init during a report
    @(negedge clk);
    req = 1'b1; idle = 1'b0; idx = 2'd0;
    repeat (3) begin
      @(negedge clk);
      check("req_no_idle_valid", int'(valid_cnt), 0);
    end
    idle = 1'b1;
    @(negedge clk);
    check("idle_rise_valid", int'(valid_cnt), 1);
    check("idle_rise_data", int'(data_cnt), 16);
    init = 1'b1;
    @(negedge clk);
    check("init_valid", int'(valid_cnt), 0);
    check("init_data", int'(data_cnt), 0);
    init = 1'b0;
    @(negedge clk);
    check("post_init_valid", int'(valid_cnt), 1);
    check("post_init_data", int'(data_cnt), 0);
    idle = 1'b0;
    @(negedge clk);
    check("idle_drop_valid", int'(valid_cnt), 0);
    rd_release();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
